// File: rtl/scan_138_ctrl.sv
// Scan controller for a 74x138-style 3-to-8 decoder: it walks the enabled channels,
// holding the decoder disabled for a blanking period before enabling each channel.
module scan_138_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic [3:0]         blank_i,
  input  logic [7:0]         chan_mask_i,
  output logic               select_a_o,
  output logic               select_b_o,
  output logic               select_c_o,
  output logic               g1_en_o,
  output logic               g2a_en_n_o,
  output logic               g2b_en_n_o,
  output logic [2:0]         chan_o,
  output logic               busy_o,
  output logic               frame_done_o
);

  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_t;

  state_t             state;
  logic [2:0]         chan;
  logic [DWELL_W-1:0] dwell_q;
  logic [3:0]         blank_q;
  logic [7:0]         mask_q;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [3:0]         blank_cnt;
  logic               g1_en;
  logic               busy;
  logic               frame_done;
  logic [2:0]         nxt_chan;
  logic               wrap;

  function automatic logic [2:0] lowest_bit(input logic [7:0] mask);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (mask[i]) idx = 3'(i);
    return idx;
  endfunction

  // Searching from the farthest offset down lets the nearest set bit win; a lone
  // channel finds nothing and keeps its own index, which then counts as a wrap.
  function automatic logic [2:0] next_chan(input logic [7:0] mask, input logic [2:0] cur);
    logic [2:0] idx;
    logic [2:0] cand;
    idx = cur;
    for (int i = 7; i >= 1; i--) begin
      cand = cur + 3'(i);
      if (mask[cand]) idx = cand;
    end
    return idx;
  endfunction

  always_comb begin
    nxt_chan = next_chan(mask_q, chan);
    wrap     = (nxt_chan <= chan);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      chan       <= 3'd0;
      dwell_q    <= '0;
      blank_q    <= 4'd0;
      mask_q     <= 8'd0;
      dwell_cnt  <= '0;
      blank_cnt  <= 4'd0;
      g1_en      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !stop_i && (chan_mask_i != 8'd0)) begin
            dwell_q   <= dwell_i;
            blank_q   <= blank_i;
            mask_q    <= chan_mask_i;
            chan      <= lowest_bit(chan_mask_i);
            blank_cnt <= 4'd0;
            busy      <= 1'b1;
            state     <= BLANK;
          end
        end
        BLANK: begin
          if (stop_i) begin
            state <= IDLE;
            busy  <= 1'b0;
            g1_en <= 1'b0;
          end else if (blank_cnt == blank_q) begin
            dwell_cnt <= '0;
            g1_en     <= 1'b1;
            state     <= ACTIVE;
          end else begin
            blank_cnt <= blank_cnt + 4'd1;
          end
        end
        ACTIVE: begin
          if (stop_i) begin
            state <= IDLE;
            busy  <= 1'b0;
            g1_en <= 1'b0;
          end else if (dwell_cnt == dwell_q) begin
            chan       <= nxt_chan;
            frame_done <= wrap;
            blank_cnt  <= 4'd0;
            g1_en      <= 1'b0;
            state      <= BLANK;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          g1_en <= 1'b0;
        end
      endcase
    end
  end

  // Select lines follow chan directly so the address is already stable during BLANK.
  assign chan_o       = chan;
  assign select_a_o   = chan[0];
  assign select_b_o   = chan[1];
  assign select_c_o   = chan[2];
  assign g1_en_o      = g1_en;
  assign g2a_en_n_o   = ~g1_en;
  assign g2b_en_n_o   = ~g1_en;
  assign busy_o       = busy;
  assign frame_done_o = frame_done;

endmodule

// File: tb/tb_scan_138_ctrl.sv
// Self-checking bench for scan_138_ctrl: each run is compared cycle by cycle against a
// schedule of (channel, active, frame_done) slots built from the scan rules.
module tb_scan_138_ctrl;

  localparam int DWELL_W = 8;

  logic               clk = 1'b0;
  logic               rst_i, start_i, stop_i;
  logic [DWELL_W-1:0] dwell_i;
  logic [3:0]         blank_i;
  logic [7:0]         chan_mask_i;
  logic               select_a_o, select_b_o, select_c_o;
  logic               g1_en_o, g2a_en_n_o, g2b_en_n_o;
  logic [2:0]         chan_o;
  logic               busy_o, frame_done_o;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [2:0] chan;
    logic       active;
    logic       fd;
  } slot_t;

  slot_t sched[$];

  scan_138_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .dwell_i(dwell_i), .blank_i(blank_i), .chan_mask_i(chan_mask_i),
    .select_a_o(select_a_o), .select_b_o(select_b_o), .select_c_o(select_c_o),
    .g1_en_o(g1_en_o), .g2a_en_n_o(g2a_en_n_o), .g2b_en_n_o(g2b_en_n_o),
    .chan_o(chan_o), .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected sequence after a start: per channel, blank+1 disabled slots then dwell+1
  // enabled slots; the first blank slot after a wrapping advance carries frame_done.
  task automatic build_sched(input logic [7:0] m, input int dw, input int bl, input int n);
    int    cur, nxt;
    bit    wrapped;
    slot_t s;
    sched.delete();
    cur = 0;
    while (!m[cur]) cur++;
    wrapped = 1'b0;
    while (sched.size() < n) begin
      for (int b = 0; b <= bl; b++) begin
        s.chan = 3'(cur); s.active = 1'b0; s.fd = (b == 0) && wrapped;
        sched.push_back(s);
      end
      for (int d = 0; d <= dw; d++) begin
        s.chan = 3'(cur); s.active = 1'b1; s.fd = 1'b0;
        sched.push_back(s);
      end
      nxt = cur;
      for (int k = 1; k <= 8; k++) begin
        if (m[(cur + k) % 8]) begin
          nxt = (cur + k) % 8;
          break;
        end
      end
      wrapped = (nxt <= cur);
      cur = nxt;
    end
  endtask

  function automatic logic [10:0] observe();
    return {chan_o, select_c_o, select_b_o, select_a_o, g1_en_o, g2a_en_n_o, g2b_en_n_o,
            busy_o, frame_done_o};
  endfunction

  function automatic logic [10:0] want_slot(input slot_t s);
    return {s.chan, s.chan, s.active, !s.active, !s.active, 1'b1, s.fd};
  endfunction

  function automatic logic [10:0] want_idle(input logic [2:0] c);
    return {c, c, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  endfunction

  task automatic start_run(input logic [7:0] m, input int dw, input int bl);
    chan_mask_i = m;
    dwell_i     = DWELL_W'(dw);
    blank_i     = 4'(bl);
    start_i     = 1'b1;
    step();
    start_i     = 1'b0;
  endtask

  task automatic test_reset();
    rst_i       = 1'b1;
    start_i     = 1'($urandom);
    stop_i      = 1'($urandom);
    dwell_i     = DWELL_W'($urandom);
    blank_i     = 4'($urandom);
    chan_mask_i = 8'($urandom);
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (observe() !== want_idle(3'd0))
        $display("[TB] FAIL reset cycle %0d: got %b want %b", c, observe(), want_idle(3'd0));
      else passed++;
    end
    rst_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    step();
  endtask

  task automatic run_and_stop(input string name, input logic [7:0] m, input int dw,
                              input int bl, input int n, input bit noise);
    build_sched(m, dw, bl, n);
    start_run(m, dw, bl);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      checks++;
      if (observe() !== want_slot(sched[i]))
        $display("[TB] FAIL %s cycle %0d: got %b want %b", name, i, observe(), want_slot(sched[i]));
      else passed++;
      if (noise) begin
        start_i     = 1'($urandom);
        dwell_i     = DWELL_W'($urandom);
        blank_i     = 4'($urandom);
        chan_mask_i = 8'($urandom);
      end
    end
    start_i = 1'b0;
    stop_i  = 1'b1;
    step();
    stop_i  = 1'b0;
    checks++;
    if (observe() !== want_idle(sched[n-1].chan))
      $display("[TB] FAIL %s stop: got %b want %b", name, observe(), want_idle(sched[n-1].chan));
    else passed++;
  endtask

  task automatic test_full_scan();
    int pulses;
    build_sched(8'hFF, 2, 1, 90);
    start_run(8'hFF, 2, 1);
    pulses = 0;
    for (int i = 0; i < 90; i++) begin
      if (i > 0) step();
      if (frame_done_o === 1'b1) pulses++;
      checks++;
      if (observe() !== want_slot(sched[i]))
        $display("[TB] FAIL full_scan cycle %0d: got %b want %b", i, observe(), want_slot(sched[i]));
      else passed++;
    end
    checks++;
    if (pulses != 2)
      $display("[TB] FAIL full_scan frame_done count: got %0d want 2", pulses);
    else passed++;
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    checks++;
    if (observe() !== want_idle(sched[89].chan))
      $display("[TB] FAIL full_scan stop: got %b want %b", observe(), want_idle(sched[89].chan));
    else passed++;
  endtask

  task automatic test_sparse();
    run_and_stop("sparse", 8'b1000_0100, 0, 0, 20, 1'b0);
  endtask

  task automatic test_zero_mask();
    chan_mask_i = 8'd0;
    start_i     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({busy_o, g1_en_o} !== 2'b00)
        $display("[TB] FAIL zero_mask cycle %0d: busy/g1 got %b want 00", c, {busy_o, g1_en_o});
      else passed++;
    end
    chan_mask_i = 8'hFF;
    stop_i      = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if ({busy_o, g1_en_o} !== 2'b00)
        $display("[TB] FAIL collision cycle %0d: busy/g1 got %b want 00", c, {busy_o, g1_en_o});
      else passed++;
    end
    start_i = 1'b0;
    stop_i  = 1'b0;
    step();
  endtask

  task automatic test_stop_mid_active();
    // 3rd enabled cycle of channel 1: chan 0 spans slots 0..12, chan 1 blanks at 13..14.
    build_sched(8'hFF, 10, 1, 18);
    start_run(8'hFF, 10, 1);
    for (int i = 0; i < 18; i++) begin
      if (i > 0) step();
      checks++;
      if (observe() !== want_slot(sched[i]))
        $display("[TB] FAIL stop_mid cycle %0d: got %b want %b", i, observe(), want_slot(sched[i]));
      else passed++;
      if (i == 5) begin
        dwell_i = '0; blank_i = 4'd0; chan_mask_i = 8'h80; start_i = 1'b1;
      end
      if (i == 6) start_i = 1'b0;
    end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    checks++;
    if (observe() !== want_idle(3'd1))
      $display("[TB] FAIL stop_mid idle: got %b want %b", observe(), want_idle(3'd1));
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    int hit;
    build_sched(8'b0010_0110, 3, 2, 60);
    start_run(8'b0010_0110, 3, 2);
    hit = -1;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) step();
      checks++;
      if (observe() !== want_slot(sched[i]))
        $display("[TB] FAIL reset_mid cycle %0d: got %b want %b", i, observe(), want_slot(sched[i]));
      else passed++;
      if (sched[i].chan == 3'd5 && sched[i].active) begin
        hit = i;
        break;
      end
    end
    checks++;
    if (hit < 0) $display("[TB] FAIL reset_mid reach chan5: got none want hit");
    else passed++;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    checks++;
    if (observe() !== want_idle(3'd0))
      $display("[TB] FAIL reset_mid idle: got %b want %b", observe(), want_idle(3'd0));
    else passed++;
    run_and_stop("restart", 8'b0010_0110, 1, 0, 12, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] m;
    for (int r = 0; r < 6; r++) begin
      m = 8'($urandom_range(1, 255));
      run_and_stop("random", m, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                   int'($urandom_range(20, 80)), 1'b1);
    end
  endtask

  task automatic test_max_counts();
    run_and_stop("max_counts", 8'h08, 255, 15, 549, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    dwell_i = '0; blank_i = 4'd0; chan_mask_i = 8'd0;
    test_reset();
    test_full_scan();
    test_sparse();
    test_zero_mask();
    test_stop_mid_active();
    test_reset_mid_run();
    test_random();
    test_max_counts();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/scan_138_ctrl.md
SCAN_138_CTRL -- requirements
Module: scan_138_ctrl

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the dwell-time input.
REQ-002 Ports, one clock domain; reset is synchronous and active-high:
- clk_i  in  1  Rising-edge clock; all state and outputs are registered on it.
- rst_i  in  1  Synchronous, active-high reset.
- start_i  in  1  Request to begin scanning; acted on only in IDLE.
- stop_i  in  1  Request to abort scanning; acted on in any state.
- dwell_i  in  DWELL_W  Active time per channel, in cycles minus 1.
- blank_i  in  4  Blanking time before each channel, in cycles minus 1.
- chan_mask_i  in  8  Channels to scan; bit n set = channel n scanned.
- select_a_o  out  1  Decoder select bit 0 (chan bit 0).
- select_b_o  out  1  Decoder select bit 1 (chan bit 1).
- select_c_o  out  1  Decoder select bit 2 (chan bit 2).
- g1_en_o  out  1  Decoder enable, active-high.
- g2a_en_n_o  out  1  Decoder enable, active-low.
- g2b_en_n_o  out  1  Decoder enable, active-low.
- chan_o  out  3  Current channel index.
- busy_o  out  1  High whenever the FSM is not in IDLE.
- frame_done_o  out  1  One-cycle pulse at the end of each complete scan frame.

Function
REQ-003 The block SHALL implement an FSM with three states: IDLE, BLANK and ACTIVE.
REQ-004 In IDLE, with start_i=1, stop_i=0 and chan_mask_i!=0, the block SHALL accept the start and latch dwell_i, blank_i and chan_mask_i.
- On the next cycle it SHALL be in BLANK, with chan_o set to the lowest set bit of the latched mask.
REQ-005 In IDLE, start_i with chan_mask_i=0 SHALL be ignored; the block stays in IDLE with busy_o=0.
REQ-006 The latched dwell, blank and mask values SHALL be used for the whole run; changes on those inputs while busy_o=1 SHALL have no effect.
REQ-007 start_i while busy_o=1 SHALL be ignored.
REQ-008 BLANK SHALL last exactly blank+1 cycles, with the decoder disabled:
- g1_en_o=0, g2a_en_n_o=1, g2b_en_n_o=1.
- select_*_o already driving the current chan_o, giving address setup before enable.
REQ-009 ACTIVE SHALL last exactly dwell+1 cycles, with g1_en_o=1, g2a_en_n_o=0, g2b_en_n_o=0, and select_*_o unchanged from BLANK.
REQ-010 On leaving ACTIVE, chan_o SHALL advance to the next set mask bit above the current channel, wrapping modulo 8, and the FSM SHALL enter BLANK.
REQ-011 frame_done_o SHALL pulse high for exactly one cycle, coincident with the first BLANK cycle, whenever the advance wraps.
- A wrap is an advance where the new index is less than or equal to the old index.
- With a single enabled channel, every advance is a wrap.
REQ-012 select_a_o, select_b_o and select_c_o SHALL equal chan_o[0], chan_o[1] and chan_o[2] at all times.
REQ-013 g2a_en_n_o and g2b_en_n_o SHALL always be equal, and always the inverse of g1_en_o.
REQ-014 stop_i=1 in BLANK or ACTIVE SHALL force IDLE on the next cycle.
- Enables deasserted, busy_o=0, frame_done_o=0.
- chan_o holds its last value.
REQ-015 stop_i SHALL take priority over start_i when both are high in the same cycle; the block stays in or returns to IDLE.
REQ-016 busy_o SHALL be high exactly while the FSM is in BLANK or ACTIVE.
REQ-017 The dwell and blank counters SHALL be DWELL_W and 4 bits wide respectively, and SHALL never overflow:
- Maximum dwell is 2^DWELL_W cycles.
- Maximum blank is 16 cycles.

Reset
REQ-018 When rst_i=1 at a clock edge, the block SHALL enter IDLE with all outputs at their reset values:
- chan_o=0, select_*_o=0, g1_en_o=0, g2a_en_n_o=1, g2b_en_n_o=1.
- busy_o=0, frame_done_o=0.
- Latched configuration cleared.
REQ-019 Reset SHALL override start_i and stop_i, and SHALL take effect on the next edge from any state, including mid-ACTIVE.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset: assert rst_i for 2 cycles with random inputs -> all outputs at REQ-018 values; g2a/g2b=1.
- Full scan: mask=8'hFF, dwell=2, blank=1, start pulse -> chan 0..7, each 2 BLANK + 3 ACTIVE cycles; frame_done_o pulses once per 40-cycle frame, in the BLANK cycle where chan_o returns to 0.
- Sparse mask: mask=8'b1000_0100, dwell=0, blank=0 -> chan sequence 2,7,2,7...; ACTIVE 1 cycle each; frame_done_o on every 7->2 transition.
- Zero mask and collision: start with mask=0 -> busy_o stays 0; start_i=stop_i=1 in IDLE -> stays IDLE.
- Stop mid-ACTIVE: mask=8'hFF, dwell=10, stop_i at 3rd ACTIVE cycle of chan 1 -> next cycle g1_en_o=0, busy_o=0, chan_o=1; config changes while busy ignored.
- Reset mid-run: rst_i in ACTIVE of chan 5 -> next cycle chan_o=0, enables off; a new start restarts from the lowest set mask bit.
